// File: rtl/myproject_sdiv_26s_16s_if.sv
// Block-level handshake and operand/result bus of the signed restoring divider.
// The master drives start and operands; the slave returns the held results.
interface myproject_sdiv_26s_16s_if #(
    parameter int din0_WIDTH = 26,
    parameter int din1_WIDTH = 16,
    parameter int dout_WIDTH = 26
);
    logic                  ap_start;
    logic                  ap_idle;
    logic                  ap_done;
    logic                  ap_ready;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic [dout_WIDTH-1:0] dout;
    logic [din1_WIDTH-1:0] rem;
    logic                  ovf;
    logic                  dbz;

    modport master (
        output ap_start, din0, din1,
        input  ap_idle, ap_done, ap_ready, dout, rem, ovf, dbz
    );

    modport slave (
        input  ap_start, din0, din1,
        output ap_idle, ap_done, ap_ready, dout, rem, ovf, dbz
    );
endinterface

// File: rtl/myproject_sdiv_26s_16s.sv
// Signed radix-2 restoring divider, one quotient bit per clock; truncating quotient/remainder.
// Latency: accept edge 0, ap_done high after edge W+1; no backpressure, starts only taken in IDLE.
module myproject_sdiv_26s_16s #(
    parameter int din0_WIDTH = 26,
    parameter int din1_WIDTH = 16,
    parameter int dout_WIDTH = 26
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    myproject_sdiv_26s_16s_if.slave  bus
);

    localparam int W  = din0_WIDTH;
    localparam int D  = din1_WIDTH;
    localparam int PW = D + 2;
    localparam int CW = $clog2(W);

    localparam logic [W-1:0] MIN_Q = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAX_Q = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                state_q;
    logic [W-1:0]          dvd_q;      // dividend magnitude, refilled with quotient bits from the LSB
    logic [D:0]            dsr_q;
    logic [PW-1:0]         pr_q;
    logic [CW-1:0]         cnt_q;
    logic                  neg_a_q;
    logic                  neg_b_q;
    logic                  min_a_q;
    logic                  zero_b_q;
    logic [dout_WIDTH-1:0] dout_q;
    logic [D-1:0]          rem_q;
    logic                  ovf_q;
    logic                  dbz_q;
    logic                  done_q;
    logic                  idle_q;

    logic [W-1:0]          a_abs;
    logic [D:0]            b_ext;
    logic [D:0]            b_abs;
    logic [PW-1:0]         pr_sh;
    logic [PW-1:0]         trial;
    logic                  q_neg;
    logic [PW-1:0]         rem_full;
    logic [dout_WIDTH-1:0] dout_d;
    logic [D-1:0]          rem_d;
    logic                  ovf_d;
    logic                  dbz_d;
    logic                  unused_rem_hi;

    // W unsigned bits hold 2^(W-1) exactly, so the most negative dividend needs no special path.
    assign a_abs = bus.din0[W-1] ? -bus.din0 : bus.din0;
    assign b_ext = {bus.din1[D-1], bus.din1};
    assign b_abs = b_ext[D] ? -b_ext : b_ext;

    assign pr_sh = {pr_q[PW-2:0], dvd_q[W-1]};
    assign trial = pr_sh - {1'b0, dsr_q};

    always_comb begin
        q_neg    = neg_a_q ^ neg_b_q;
        rem_full = neg_a_q ? -pr_q : pr_q;
        dout_d   = q_neg ? -dvd_q : dvd_q;
        rem_d    = rem_full[D-1:0];
        ovf_d    = 1'b0;
        dbz_d    = 1'b0;
        if (zero_b_q) begin
            dout_d = neg_a_q ? MIN_Q : MAX_Q;
            rem_d  = '0;
            dbz_d  = 1'b1;
        end else if (min_a_q && !q_neg && (dvd_q == MIN_Q)) begin
            dout_d = MAX_Q;
            rem_d  = '0;
            ovf_d  = 1'b1;
        end
    end

    // |rem| < |divisor| <= 2^(D-1), so the upper remainder bits never carry information.
    assign unused_rem_hi = ^rem_full[PW-1:D];

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q  <= IDLE;
            dvd_q    <= '0;
            dsr_q    <= '0;
            pr_q     <= '0;
            cnt_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            min_a_q  <= 1'b0;
            zero_b_q <= 1'b0;
            dout_q   <= '0;
            rem_q    <= '0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
            idle_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.ap_start) begin
                        state_q  <= CALC;
                        idle_q   <= 1'b0;
                        dvd_q    <= a_abs;
                        dsr_q    <= b_abs;
                        neg_a_q  <= bus.din0[W-1];
                        neg_b_q  <= bus.din1[D-1];
                        min_a_q  <= (bus.din0 == MIN_Q);
                        zero_b_q <= (bus.din1 == '0);
                        pr_q     <= '0;
                        cnt_q    <= CW'(W - 1);
                    end
                end
                CALC: begin
                    dvd_q <= {dvd_q[W-2:0], ~trial[PW-1]};
                    pr_q  <= trial[PW-1] ? pr_sh : trial;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    dout_q  <= dout_d;
                    rem_q   <= rem_d;
                    ovf_q   <= ovf_d;
                    dbz_q   <= dbz_d;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    idle_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ap_idle  = idle_q;
    assign bus.ap_done  = done_q;
    assign bus.ap_ready = done_q;
    assign bus.dout     = dout_q;
    assign bus.rem      = rem_q;
    assign bus.ovf      = ovf_q;
    assign bus.dbz      = dbz_q;

endmodule
